fifo_wr_arb: RTL
================

# fifo_wr_arb

Round-robin write-port arbiter for the shared async FIFO (`fifo`). It lets `NREQ` producers in the write-clock domain share the FIFO's single `winc`/`wdata` port. Each grant is a bounded burst of up to `BURST_LEN` words, with backpressure from `wfull` and `prog_full`. It sits directly in front of the FIFO write side and runs on the FIFO write clock.

## Interface
- `NREQ`, default 4: number of requesters, range 2..8.
- `DW`, default 16: data width; equals the FIFO `DWI`.
- `BURST_LEN`, default 4: maximum words per grant, range 1..16.
- `clk`  in  1: FIFO write clock (drives `wclk`).
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  `NREQ`: requester i has a valid word on its `din` slice.
- `din`  in  `NREQ*DW`: requester i data at `[i*DW +: DW]`.
- `ack`  out  `NREQ`: one-hot, combinational; word of requester i is written this cycle.
- `grant`  out  `NREQ`: one-hot registered burst owner; all-zero when idle.
- `busy`  out  1: registered; high in BURST state.
- `winc`  out  1: combinational FIFO write enable.
- `wdata`  out  `DW`: combinational; the owner's `din` slice (don't-care when `winc`=0).
- `wfull`  in  1: FIFO full, in the `clk` domain.
- `prog_full`  in  1: FIFO programmable-full threshold reached.

## Operation
- States: IDLE, BURST. Registers: `state`, `owner` ($clog2(NREQ) bits), `ptr` (round-robin start index), `cnt` ($clog2(BURST_LEN)+1 bits).
- Reset values: IDLE, `owner`=0, `ptr`=0, `cnt`=0. This gives `grant`=0, `busy`=0, `winc`=0, `ack`=0.
- IDLE:
  - If `prog_full`=0 and `req` is nonzero, pick the first i with `req[i]`=1, scanning `ptr`, `ptr`+1, … modulo `NREQ`.
  - Then: `owner`←i, `cnt`←0, go to BURST.
  - Otherwise stay in IDLE.
- BURST, write condition: `winc` = `req[owner]` & ~`wfull`; `ack[owner]` = `winc`, all other `ack` bits 0; `wdata` = `din[owner]`.
- BURST, accepted word (`winc`=1): `cnt`←`cnt`+1. If `cnt`=`BURST_LEN`-1, this is the last word: go to IDLE and set `ptr`←(`owner`+1) mod `NREQ`.
- BURST, requester withdraws (`req[owner]`=0): go to IDLE and set `ptr`←(`owner`+1) mod `NREQ`. No word is written that cycle.
- BURST, stall (`req[owner]`=1 and `wfull`=1): hold `state`, `owner`, `cnt`; `winc`=0.
- `prog_full` rising during BURST does not truncate the burst; only `wfull` stalls it. `prog_full` only gates new grants in IDLE.
- `grant` = one-hot(`owner`) when `state`=BURST, else 0. `busy` = (`state`=BURST).
- Requesters must hold `req` and `din` stable until `ack`. `req` may be deasserted at any time; no word is lost, because a word is either acked or still held by the requester.
- `ptr` wraps from `NREQ`-1 to 0. If `req` is nonzero only for requesters that lost the last arbitration, it is still served; the arbiter is work-conserving.

## Timing
- Arbitration costs one IDLE cycle. Requests sampled at IDLE cycle t produce `grant`/`busy` from t+1; the first `winc` can occur at t+1.
- Full-rate burst: `BURST_LEN` consecutive `winc` cycles, then one IDLE cycle. Steady-state throughput with all requesters active is `BURST_LEN`/(`BURST_LEN`+1).
- `winc`, `ack` and `wdata` have zero latency from `req`/`wfull` within BURST. The combinational path is `wfull` → `winc`.
- Synchronous reset in any state: IDLE on the next edge. Outputs take reset values from that edge. In-flight bursts are abandoned with no partial state kept, and `ptr` returns to 0.
- If `req[owner]` drops and `wfull` rises in the same cycle, the withdrawal rule applies: go to IDLE.
- `BURST_LEN`=1: every word is its own grant, so one word per two cycles.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `req`=4'b1111. Required: `grant`=0, `busy`=0, `winc`=0, `ack`=0 throughout. After release, `grant`=4'b0001 one cycle after the first IDLE cycle.
- Round-robin: `req`=4'b1111 constant, `wfull`=`prog_full`=0, `BURST_LEN`=4. Required:
  - owner sequence 0,1,2,3,0;
  - each owner gets 4 `winc` cycles, followed by 1 idle cycle;
  - 16 words in 20 cycles;
  - `wdata` matches the owner's `din` slice on every `winc`.
- Early withdrawal: only `req[2]`=1, dropped after 2 acks. Required: exactly 2 `winc`, then `busy`=0 next cycle. A subsequent `req`=4'b0101 grants requester 0 (`ptr`=3 wraps to 0).
- Stall: `wfull`=1 for 3 cycles after word 2 of a burst. Required: `winc`/`ack`=0 for those 3 cycles, `grant` unchanged; the burst then completes with 2 more words (4 total).
- `prog_full`:
  - asserted in IDLE with `req`=4'b1000: no grant until `prog_full`=0, then `grant`=4'b1000 the following cycle;
  - asserted mid-burst: the burst still delivers all 4 words.
- Reset mid-burst: `rst` pulsed after word 1 of owner 1. Required: `grant`=0 and `winc`=0 from the next edge. After release with `req`=4'b1111, the next owner is 0.

Source files
------------

// File: rtl/fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arb
// Brief    : Round-robin burst arbiter sharing one FIFO write port among
//            NREQ producers, with wfull stall and prog_full grant gating.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arb #(
    parameter int NREQ      = 4,
    parameter int DW        = 16,
    parameter int BURST_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   din,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic                 winc,
    output logic [DW-1:0]        wdata,
    input  logic                 wfull,
    input  logic                 prog_full
);

    localparam int OW = $clog2(NREQ);
    localparam int CW = $clog2(BURST_LEN) + 1;
    localparam logic [CW-1:0] C_LAST      = CW'(BURST_LEN - 1);
    localparam logic [OW-1:0] C_OWNER_MAX = OW'(NREQ - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [OW-1:0] r_owner, w_owner_nxt;
    logic [OW-1:0] r_ptr,   w_ptr_nxt;
    logic [CW-1:0] r_cnt,   w_cnt_nxt;
    logic [OW-1:0] w_pick, w_idx, w_owner_inc;
    logic          w_found;
    logic [DW-1:0] w_din_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign w_din_arr[gi] = din[gi*DW +: DW];
    end

    // Scan from ptr+NREQ-1 down to ptr so the index closest to ptr wins last.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = OW'((int'(r_ptr) + k) % NREQ);
            if (req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_owner_inc = (r_owner == C_OWNER_MAX) ? '0 : r_owner + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        winc        = 1'b0;
        ack         = '0;
        grant       = '0;
        busy        = 1'b0;
        wdata       = w_din_arr[r_owner];
        case (r_state)
            S_IDLE: begin
                if (!prog_full && w_found) begin
                    w_owner_nxt = w_pick;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                busy           = 1'b1;
                grant[r_owner] = 1'b1;
                // Withdrawal takes priority over a simultaneous wfull.
                if (!req[r_owner]) begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = w_owner_inc;
                end else if (!wfull) begin
                    winc         = 1'b1;
                    ack[r_owner] = 1'b1;
                    w_cnt_nxt    = r_cnt + 1'b1;
                    if (r_cnt == C_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_ptr_nxt   = w_owner_inc;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule
`default_nettype wire
